fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Parametrised next-generation instruction fetch and sequencing block for the single-cycle core. It replaces the bare program counter and the fixed "PC == 128" done compare. It adds:
- a start/run/halt state machine,
- a writable jump-target lookup table supporting absolute and PC-relative branches,
- pipeline stall support,
- a saturating cycle counter.

It sits between the control decoder (jump, halt and stall requests) and the instruction ROM (prog_ctr).

Parameters:
- D, 12, program counter width in bits.
- L, 5, jump LUT index width; the LUT depth is 2^L entries, each D bits wide.
- DONE_ADDR, 128, PC value that forces the halt state when reached.
- CW, 16, cycle counter width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  level, sampled in IDLE or HALT; begins a run from PC 0.
- stall  input  1  holds the PC and suppresses all jump/halt actions this cycle.
- absjump_en  input  1  next PC = lut[target_idx].
- reljump_en  input  1  next PC = prog_ctr + lut[target_idx], where the LUT entry is a D-bit two's-complement offset.
- halt  input  1  halt request from the control decoder.
- target_idx  input  L  jump LUT read index.
- lut_we  input  1  LUT write enable.
- lut_waddr  input  L  LUT write index.
- lut_wdata  input  D  LUT write data.
- prog_ctr  output  D  current fetch address to the instruction ROM.
- fetch_valid  output  1  current prog_ctr is an executing instruction.
- busy  output  1  state is RUN.
- done  output  1  state is HALT; held until restart.
- cycle_count  output  CW  RUN cycles since the last start.

Behaviour:
- **States:** IDLE, RUN, HALT. All outputs are registered except fetch_valid and busy, which decode combinationally from the state and stall.
- **Reset (async, any time, including mid-run):**
  - state = IDLE, prog_ctr = 0, cycle_count = 0.
  - done = 0, busy = 0, fetch_valid = 0.
  - LUT contents are not reset. LUT contents are undefined until written.
- **IDLE:**
  - start = 1 moves to RUN on the next edge with prog_ctr = 0 and cycle_count = 0.
  - All other inputs except the LUT write port are ignored.
- **RUN:**
  - busy = 1 and fetch_valid = !stall.
  - cycle_count increments every RUN cycle, including stalled ones, and saturates at 2^CW-1.
- **RUN with stall = 1:** prog_ctr holds; halt and jump enables are ignored.
- **RUN with stall = 0,** next-PC priority (highest first):
  1. halt → HALT, prog_ctr holds.
  2. absjump_en → lut[target_idx].
  3. reljump_en → prog_ctr + lut[target_idx], modulo 2^D.
  4. Otherwise prog_ctr + 1, modulo 2^D; wrap from 2^D-1 to 0 is legal.
  - If absjump_en and reljump_en are both set, absjump_en wins.
- **DONE_ADDR:** when the registered prog_ctr equals DONE_ADDR in RUN and stall = 0, the next state is HALT and prog_ctr holds. The instruction at DONE_ADDR is presented but fetch_valid = 0 for it. The DONE_ADDR compare has priority over halt and jumps.
- **Jump landing on DONE_ADDR:** the PC takes that value; HALT follows on the next cycle.
- **HALT:**
  - done = 1, busy = 0, fetch_valid = 0.
  - prog_ctr and cycle_count are frozen.
  - start = 1 restarts: next edge is RUN, prog_ctr = 0, cycle_count = 0, done = 0.
  - start while in RUN is ignored.
- **Jump LUT:**
  - Read is combinational on target_idx.
  - Writes are synchronous and allowed in every state.
  - A write and a read of the same index in the same cycle returns the old value; the new value is visible from the next cycle.
- **Latency:**
  - Jump and halt requests take effect at the next rising edge.
  - done rises one cycle after the halting cycle.

Test Plan:
1. Reset, then start pulse → prog_ctr steps 0,1,2,… each cycle. busy = 1. cycle_count = 5 after 5 RUN cycles. Reaching prog_ctr = 128 → done = 1 next cycle, prog_ctr stays 128, cycle_count frozen at 129.
2. Write lut[3] = 40, then at prog_ctr = 10 assert absjump_en with target_idx = 3 → next prog_ctr = 40. Write lut[4] = 12'hFFC (−4), reljump_en at PC 40 → 36. Both enables at PC 36 with idx 3 → 40, absolute wins.
3. stall held 3 cycles at PC 7, with halt and absjump_en also asserted → prog_ctr stays 7, fetch_valid = 0, cycle_count advances by 3. Release stall with halt still set → HALT, done = 1.
4. Instantiate D = 4, DONE_ADDR = 20 (unreachable), run → prog_ctr wraps 15 → 0 without halting. Instantiate CW = 3 → cycle_count saturates at 7.
5. Assert reset asynchronously mid-run at PC 55 between clock edges → prog_ctr = 0, busy = 0, done = 0 immediately. lut[3] still reads 40. Restart with start → normal run from 0.
6. In HALT, assert start → RUN from PC 0, done = 0, cycle_count restarts. Same-cycle lut_we to idx 3 with value 99 while absjump_en reads idx 3 → jump to old value 40; a jump next cycle → 99.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: IDLE/RUN/HALT control, LUT-driven jumps, stall hold, saturating cycle counter.
// Jump/halt act at the next edge; stall freezes the PC and masks jump/halt while cycles keep counting.
module fetch_sequencer #(
    parameter int D         = 12,
    parameter int L         = 5,
    parameter int DONE_ADDR = 128,
    parameter int CW        = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stall,
    input  logic          absjump_en,
    input  logic          reljump_en,
    input  logic          halt,
    input  logic [L-1:0]  target_idx,
    input  logic          lut_we,
    input  logic [L-1:0]  lut_waddr,
    input  logic [D-1:0]  lut_wdata,
    output logic [D-1:0]  prog_ctr,
    output logic          fetch_valid,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cycle_count
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    localparam logic [31:0] DONE_VAL = 32'(DONE_ADDR);

    state_t       state;
    logic [D-1:0] lut [2**L];
    logic [D-1:0] lut_rd;
    logic         at_done;

    assign lut_rd  = lut[target_idx];
    // DONE_ADDR may lie outside the PC range, in which case it never matches
    assign at_done = (32'(prog_ctr) == DONE_VAL);

    assign busy        = (state == RUN);
    assign fetch_valid = (state == RUN) && !stall && !at_done;

    always_ff @(posedge clk) begin
        if (lut_we) begin
            lut[lut_waddr] <= lut_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            prog_ctr    <= '0;
            cycle_count <= '0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state       <= RUN;
                        prog_ctr    <= '0;
                        cycle_count <= '0;
                        done        <= 1'b0;
                    end
                end
                RUN: begin
                    if (cycle_count != '1) begin
                        cycle_count <= cycle_count + CW'(1);
                    end
                    if (!stall) begin
                        if (at_done || halt) begin
                            state <= HALT;
                            done  <= 1'b1;
                        end else if (absjump_en) begin
                            prog_ctr <= lut_rd;
                        end else if (reljump_en) begin
                            prog_ctr <= prog_ctr + lut_rd;
                        end else begin
                            prog_ctr <= prog_ctr + D'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboarded bench for fetch_sequencer: a default-size instance under directed and random stimulus,
// plus a narrow instance (D=4, CW=3) for PC wrap and counter saturation.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, stall = 1'b0, absjump_en = 1'b0, reljump_en = 1'b0, halt = 1'b0;
    logic [4:0]  target_idx = '0, lut_waddr = '0;
    logic        lut_we = 1'b0;
    logic [11:0] lut_wdata = '0;
    logic [11:0] prog_ctr;
    logic        fetch_valid, busy, done;
    logic [15:0] cycle_count;

    logic        s_reset = 1'b1, s_start = 1'b0;
    logic [3:0]  s_prog_ctr;
    logic        s_fetch_valid, s_busy, s_done;
    logic [2:0]  s_cycle_count;

    fetch_sequencer #(.D(12), .L(5), .DONE_ADDR(128), .CW(16)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .absjump_en(absjump_en), .reljump_en(reljump_en), .halt(halt),
        .target_idx(target_idx), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .prog_ctr(prog_ctr), .fetch_valid(fetch_valid), .busy(busy), .done(done),
        .cycle_count(cycle_count)
    );

    fetch_sequencer #(.D(4), .L(2), .DONE_ADDR(20), .CW(3)) dut_small (
        .clk(clk), .reset(s_reset), .start(s_start), .stall(1'b0),
        .absjump_en(1'b0), .reljump_en(1'b0), .halt(1'b0),
        .target_idx(2'b00), .lut_we(1'b0), .lut_waddr(2'b00), .lut_wdata(4'h0),
        .prog_ctr(s_prog_ctr), .fetch_valid(s_fetch_valid), .busy(s_busy), .done(s_done),
        .cycle_count(s_cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pc;
        bit busy;
        bit done;
        bit fv;
        int cc;
    } exp_t;

    exp_t mq[$];
    exp_t sq[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: run/halt flags, PC and counter as plain integers
    bit m_run = 0, m_halt = 0;
    int m_pc = 0, m_cc = 0;
    int m_lut[32];
    bit s_run = 0;
    int s_pc = 0, s_cc = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            #2;
            if (mq.size() > 0) begin
                e = mq.pop_front();
                check("pc", int'(prog_ctr), e.pc);
                check("busy", int'(busy), int'(e.busy));
                check("done", int'(done), int'(e.done));
                check("fetch_valid", int'(fetch_valid), int'(e.fv));
                check("cycle_count", int'(cycle_count), e.cc);
            end
            if (sq.size() > 0) begin
                e = sq.pop_front();
                check("s_pc", int'(s_prog_ctr), e.pc);
                check("s_busy", int'(s_busy), int'(e.busy));
                check("s_done", int'(s_done), int'(e.done));
                check("s_fetch_valid", int'(s_fetch_valid), int'(e.fv));
                check("s_cycle_count", int'(s_cycle_count), e.cc);
            end
        end
    end

    task automatic step(input bit st, input bit stl, input bit ab, input bit rl, input bit hl,
                        input int idx, input bit we, input int wa, input int wd);
        exp_t e;
        int   rd;
        start = st; stall = stl; absjump_en = ab; reljump_en = rl; halt = hl;
        target_idx = 5'(idx); lut_we = we; lut_waddr = 5'(wa); lut_wdata = 12'(wd);
        e.pc = m_pc; e.busy = m_run; e.done = m_halt; e.cc = m_cc;
        e.fv = m_run && !stl && (m_pc != 128);
        mq.push_back(e);
        rd = m_lut[idx];
        if (!m_run && st) begin
            m_run = 1; m_halt = 0; m_pc = 0; m_cc = 0;
        end else if (m_run) begin
            if (m_cc < 65535) m_cc++;
            if (!stl) begin
                if (m_pc == 128 || hl) begin
                    m_run = 0; m_halt = 1;
                end else if (ab) m_pc = rd;
                else if (rl) m_pc = (m_pc + rd) % 4096;
                else m_pc = (m_pc + 1) % 4096;
            end
        end
        if (we) m_lut[wa] = wd;
        @(negedge clk);
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic run_to(input int pc);
        for (int i = 0; i < 600 && m_pc != pc; i++) idle_step();
    endtask

    task automatic do_reset();
        exp_t e;
        reset = 1'b1;
        start = 0; stall = 0; absjump_en = 0; reljump_en = 0; halt = 0; lut_we = 0;
        m_run = 0; m_halt = 0; m_pc = 0; m_cc = 0;
        e.pc = 0; e.busy = 0; e.done = 0; e.fv = 0; e.cc = 0;
        mq.push_back(e);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic small_step(input bit st);
        exp_t e;
        s_start = st;
        e.pc = s_pc; e.busy = s_run; e.done = 0; e.fv = s_run; e.cc = s_cc;
        sq.push_back(e);
        if (!s_run && st) begin
            s_run = 1; s_pc = 0; s_cc = 0;
        end else if (s_run) begin
            if (s_cc < 7) s_cc++;
            s_pc = (s_pc + 1) % 16;
        end
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);

        // Narrow instance: wrap 15->0 twice, counter pinned at 7
        small_step(0);
        s_reset = 1'b0;
        small_step(1);
        repeat (40) small_step(0);

        do_reset();
        // Fill the LUT while IDLE, with junk on the control inputs that must be ignored
        for (int i = 0; i < 32; i++)
            step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 31), 1, i, $urandom_range(0, 4095));
        step(0, 0, 0, 0, 0, 0, 1, 3, 40);
        step(0, 0, 0, 0, 0, 0, 1, 4, 12'hFFC);
        step(0, 0, 0, 0, 0, 0, 1, 7, 128);
        step(0, 0, 0, 0, 0, 0, 1, 8, 4094);

        // Straight run to DONE_ADDR, then frozen in HALT
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        run_to(128);
        repeat (2) idle_step();
        repeat (3) step(0, 0, 1, 1, 1, 3, 0, 0, 0);

        // Absolute, relative, and both-enables jumps
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        run_to(10);
        step(0, 0, 1, 0, 0, 3, 0, 0, 0);
        step(0, 0, 0, 1, 0, 4, 0, 0, 0);
        step(0, 0, 1, 1, 0, 3, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle_step();

        // Stall masks halt and jump; releasing it lets halt through
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        run_to(7);
        repeat (3) step(0, 1, 1, 0, 1, 3, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        repeat (2) idle_step();

        // Jump landing on DONE_ADDR halts one cycle later
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) idle_step();
        step(0, 0, 1, 0, 0, 7, 0, 0, 0);
        repeat (2) idle_step();

        // Mid-run async reset; LUT survives
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        run_to(55);
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle_step();
        step(0, 0, 1, 0, 0, 3, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle_step();

        // Restart from HALT; same-cycle LUT write reads the old entry
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        run_to(5);
        step(0, 0, 1, 0, 0, 3, 1, 3, 99);
        step(0, 0, 1, 0, 0, 3, 0, 0, 0);
        step(0, 0, 1, 0, 0, 8, 0, 0, 0);
        repeat (4) idle_step();

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else
                step($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                     $urandom_range(0, 39) == 0, $urandom_range(0, 31),
                     $urandom_range(0, 7) == 0, $urandom_range(0, 31), $urandom_range(0, 4095));
        end

        repeat (3) @(negedge clk);
        check("queue_drained", mq.size() + sq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
